supply_access_arbiter: RTL

//  Owns the per-item stock counters of the vending machine. Arbitrates between

---
 rtl/vend_pkg.sv | 9 +
 rtl/stock_regfile.sv | 31 +++
 rtl/supply_access_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, requester ids and index-width helper for the stock arbiter.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT, DONE} state_e;
  localparam logic REQ_OWN = 1'b0;
  localparam logic REQ_CUS = 1'b1;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stock_regfile.sv
// stock_regfile: per-slot stock counters with one comb read, one sync write and flat readout.
module stock_regfile #(
  parameter int NUM_ITEMS  = 4,
  parameter int CNT_W      = 4,
  parameter int INIT_STOCK = 0,
  parameter int IDX_W      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [CNT_W-1:0]           rd_data,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [CNT_W-1:0]           wr_data,
  output logic [NUM_ITEMS*CNT_W-1:0] flat
);
  localparam logic [CNT_W-1:0] INIT = INIT_STOCK[CNT_W-1:0];
  localparam logic [IDX_W:0]   NUM  = NUM_ITEMS[IDX_W:0];
  logic [CNT_W-1:0] mem_q [NUM_ITEMS];
  assign rd_data = ({1'b0, rd_idx} < NUM) ? mem_q[rd_idx] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ITEMS; k++) mem_q[k] <= INIT;
    end else if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_flat
    assign flat[i*CNT_W +: CNT_W] = mem_q[i];
  end
endmodule

// File: rtl/supply_access_arbiter.sv
// supply_access_arbiter: arbitrates owner restock vs customer vend, sequences
// each through lookup/commit/done and drives dispense and the redlight lamp.
module supply_access_arbiter import vend_pkg::*; #(
  parameter int NUM_ITEMS    = 4,
  parameter int CNT_W        = 4,
  parameter int MAX_STOCK    = 15,
  parameter int INIT_STOCK   = 0,
  parameter int REDLIGHT_CYC = 2,
  localparam int IDX_W       = idx_w(NUM_ITEMS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       own_req,
  input  logic [IDX_W-1:0]           own_item,
  input  logic [CNT_W-1:0]           own_qty,
  output logic                       own_ack,
  output logic                       own_ok,
  input  logic                       cus_req,
  input  logic [IDX_W-1:0]           cus_item,
  output logic                       cus_ack,
  output logic                       cus_ok,
  output logic                       dispense,
  output logic [IDX_W-1:0]           disp_item,
  output logic                       redlight,
  output logic                       busy,
  output logic [NUM_ITEMS*CNT_W-1:0] stock_flat
);
  localparam int RL_W = $clog2(REDLIGHT_CYC + 1);
  localparam logic [CNT_W:0]   MAX     = MAX_STOCK[CNT_W:0];
  localparam logic [IDX_W:0]   NUM     = NUM_ITEMS[IDX_W:0];
  localparam logic [RL_W-1:0]  RL_LOAD = REDLIGHT_CYC[RL_W-1:0];
  state_e           state_q;
  logic             req_q, alt_q, busy_q;
  logic             own_ack_q, own_ok_q, cus_ack_q, cus_ok_q, dispense_q;
  logic [IDX_W-1:0] item_q, disp_item_q;
  logic [CNT_W-1:0] qty_q, stock_q, rd_data, wr_data;
  logic [CNT_W:0]   sum_q;
  logic [RL_W-1:0]  rl_q;
  logic             own_elig, grant_cus, item_ok, ok, we;
  assign own_elig  = own_req & mode;
  // Customer beats an eligible owner only when the owner took the last grant over a waiting customer.
  assign grant_cus = cus_req & (~own_elig | alt_q);
  assign item_ok   = {1'b0, item_q} < NUM;
  always_comb begin
    ok      = item_ok & ((req_q == REQ_OWN) ? (sum_q <= MAX) : (stock_q != '0));
    we      = (state_q == COMMIT) & item_ok & ((req_q == REQ_OWN) | ok);
    wr_data = (req_q == REQ_OWN) ? ((sum_q > MAX) ? MAX[CNT_W-1:0] : sum_q[CNT_W-1:0])
                                 : stock_q - CNT_W'(1);
  end
  stock_regfile #(
    .NUM_ITEMS(NUM_ITEMS), .CNT_W(CNT_W), .INIT_STOCK(INIT_STOCK), .IDX_W(IDX_W)
  ) u_regfile (
    .clk(clk), .rst(rst), .rd_idx(item_q), .rd_data(rd_data),
    .we(we), .wr_idx(item_q), .wr_data(wr_data), .flat(stock_flat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= REQ_OWN;
      alt_q       <= 1'b0;
      busy_q      <= 1'b0;
      item_q      <= '0;
      qty_q       <= '0;
      stock_q     <= '0;
      sum_q       <= '0;
      own_ack_q   <= 1'b0;
      own_ok_q    <= 1'b0;
      cus_ack_q   <= 1'b0;
      cus_ok_q    <= 1'b0;
      dispense_q  <= 1'b0;
      disp_item_q <= '0;
      rl_q        <= '0;
    end else begin
      rl_q <= (state_q == COMMIT && !ok) ? RL_LOAD : ((rl_q != '0) ? rl_q - RL_W'(1) : rl_q);
      case (state_q)
        IDLE: if (own_elig | cus_req) begin
          req_q   <= grant_cus ? REQ_CUS : REQ_OWN;
          item_q  <= grant_cus ? cus_item : own_item;
          qty_q   <= own_qty;
          alt_q   <= ~grant_cus & cus_req;
          busy_q  <= 1'b1;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          stock_q <= rd_data;
          sum_q   <= {1'b0, rd_data} + {1'b0, qty_q};
          state_q <= COMMIT;
        end
        COMMIT: begin
          own_ack_q  <= req_q == REQ_OWN;
          own_ok_q   <= (req_q == REQ_OWN) & ok;
          cus_ack_q  <= req_q == REQ_CUS;
          cus_ok_q   <= (req_q == REQ_CUS) & ok;
          dispense_q <= (req_q == REQ_CUS) & ok;
          if ((req_q == REQ_CUS) && ok) disp_item_q <= item_q;
          state_q    <= DONE;
        end
        DONE: begin
          own_ack_q  <= 1'b0;
          own_ok_q   <= 1'b0;
          cus_ack_q  <= 1'b0;
          cus_ok_q   <= 1'b0;
          dispense_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign own_ack   = own_ack_q;
  assign own_ok    = own_ok_q;
  assign cus_ack   = cus_ack_q;
  assign cus_ok    = cus_ok_q;
  assign dispense  = dispense_q;
  assign disp_item = disp_item_q;
  assign redlight  = rl_q != '0;
  assign busy      = busy_q;
endmodule
